// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the 8-bit RISC CPU: opcode encodings, the
// eight sequencer phases and the ALU-operation classifier.
package cpu_sequencer_pkg;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  // All eight codes are used, so the phase counter wraps 7 -> 0 naturally.
  typedef enum logic [2:0] {
    PH_INST_ADDR  = 3'd0,
    PH_INST_FETCH = 3'd1,
    PH_INST_LOAD  = 3'd2,
    PH_IDLE       = 3'd3,
    PH_OP_ADDR    = 3'd4,
    PH_OP_FETCH   = 3'd5,
    PH_ALU_OP     = 3'd6,
    PH_STORE      = 3'd7
  } phase_e;

  // Opcodes that read an operand from memory and load the accumulator.
  function automatic logic is_aluop(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Control bundle between the sequencer and the CPU datapath.
// There is no valid/ready handshake here: opcode and zero are level inputs
// sampled every cycle, and every strobe is a level output that is
// meaningful for exactly the cycle in which it is high; the datapath acts on
// it at the next rising clock edge.
interface cpu_sequencer_if #(
  parameter int OPW = 3
);

  logic [OPW-1:0] opcode;
  logic           zero;
  logic           sel;
  logic           rd;
  logic           ld_ir;
  logic           inc_pc;
  logic           ld_pc;
  logic           data_e;
  logic           ld_ac;
  logic           wr;
  logic           halt;
  logic [2:0]     phase;

  // Sequencer side.
  modport master (
    input  opcode, zero,
    output sel, rd, ld_ir, inc_pc, ld_pc, data_e, ld_ac, wr, halt, phase
  );

  // Datapath side.
  modport slave (
    output opcode, zero,
    input  sel, rd, ld_ir, inc_pc, ld_pc, data_e, ld_ac, wr, halt, phase
  );

endinterface

// File: rtl/cpu_sequencer_phase_counter.sv
// 3-bit wrapping phase counter with hold and synchronous reset.
module cpu_phase_counter
  import cpu_sequencer_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   hold_i,
  output phase_e phase_o
);

  phase_e phase_q;
  phase_e phase_d;

  // Advance one phase per clock unless held.
  always_comb begin
    phase_d = phase_q;
    if (!hold_i) begin
      phase_d = phase_e'(phase_q + 3'd1);
    end
  end

  // Phase register; reset wins over hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH_INST_ADDR;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Eight-phase control sequencer for the 8-bit RISC CPU. State is the phase
// counter plus a halted flag; all strobes decode combinationally from that
// state, the current opcode and the accumulator zero flag.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int OPW         = 3,
  parameter bit HALT_STICKY = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  cpu_sequencer_if.master  bus
);

  phase_e         phase_q;
  logic           halted_q;
  logic           halted_d;
  logic           halt_entry;
  logic           hold;
  logic [OPW-1:0] op;
  logic           aluop;

  assign op    = bus.opcode;
  assign aluop = is_aluop(op);

  cpu_phase_counter u_phase (
    .clk    (clk),
    .rst    (rst),
    .hold_i (hold),
    .phase_o(phase_q)
  );

  // Halted flag: set at the end of OP_ADDR on HLT, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  // Next-state for the halted flag and the strobe decode table.
  always_comb begin
    halt_entry = 1'b0;
    halted_d   = halted_q;
    hold       = 1'b0;
    bus.sel    = 1'b0;
    bus.rd     = 1'b0;
    bus.ld_ir  = 1'b0;
    bus.inc_pc = 1'b0;
    bus.ld_pc  = 1'b0;
    bus.data_e = 1'b0;
    bus.ld_ac  = 1'b0;
    bus.wr     = 1'b0;
    bus.halt   = 1'b0;
    bus.phase  = phase_q;

    halt_entry = HALT_STICKY && !halted_q && (phase_q == PH_OP_ADDR) && (op == OP_HLT);
    halted_d   = halted_q | halt_entry;
    // The counter freezes on the entry edge too, so phase stays at OP_ADDR.
    hold       = halted_d;

    if (halted_q) begin
      // Frozen: only the halt indicator, opcode and zero are ignored.
      bus.halt = 1'b1;
    end else begin
      case (phase_q)
        PH_INST_ADDR: begin
          bus.sel = 1'b1;
        end
        PH_INST_FETCH: begin
          bus.sel = 1'b1;
          bus.rd  = 1'b1;
        end
        PH_INST_LOAD, PH_IDLE: begin
          bus.sel   = 1'b1;
          bus.rd    = 1'b1;
          bus.ld_ir = 1'b1;
        end
        PH_OP_ADDR: begin
          bus.inc_pc = 1'b1;
          bus.halt   = (op == OP_HLT);
        end
        PH_OP_FETCH: begin
          bus.rd = aluop;
        end
        PH_ALU_OP: begin
          bus.rd     = aluop;
          bus.inc_pc = (op == OP_SKZ) && bus.zero;
          bus.ld_pc  = (op == OP_JMP);
          // Drive the bus one phase early so it is settled when wr rises.
          bus.data_e = (op == OP_STO);
        end
        PH_STORE: begin
          bus.rd     = aluop;
          bus.ld_ac  = aluop;
          bus.inc_pc = (op == OP_JMP);
          bus.ld_pc  = (op == OP_JMP);
          bus.data_e = (op == OP_STO);
          bus.wr     = (op == OP_STO);
        end
        default: begin
          bus.sel = 1'b1;
        end
      endcase
    end
  end

endmodule
